// File: rtl/candy_ie_pkg.sv
// Shared CANDY instruction constants: type codes, field positions, width.
// Same values the decode stage uses to pull fields back apart.
package candy_ie_pkg;

    localparam int INSTR_W = 24;

    localparam int TYPE_LSB = 22;
    localparam int R_OP_LSB = 16;
    localparam int R_RS1_LSB = 12;
    localparam int R_RS2_LSB = 8;
    localparam int R_RD_LSB = 4;
    localparam int IS_OP_LSB = 18;
    localparam int IS_RS1_LSB = 14;
    localparam int IS_R2_LSB = 10;
    localparam int U_OP_LSB = 20;
    localparam int U_RD_LSB = 16;

    typedef enum logic [1:0] {
        TYPE_R = 2'b00,
        TYPE_I = 2'b01,
        TYPE_S = 2'b10,
        TYPE_U = 2'b11
    } itype_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    typedef struct packed {
        itype_e      typ;
        logic [5:0]  op;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [15:0] imm;
    } fields_t;

    // True when op carries set bits beyond what its format can hold.
    function automatic logic op_overflow(fields_t f);
        logic bad;
        bad = 1'b0;
        case (f.typ)
            TYPE_I, TYPE_S: bad = |f.op[5:4];
            TYPE_U:         bad = |f.op[5:2];
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/candy_ie_fifo.sv
// Synchronous FIFO for encoded words; clr_i empties it in one cycle.
// Pointers carry one extra wrap bit to tell full from empty.
module candy_ie_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, wp_d;
    logic [AW:0]  rp_q, rp_d;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty_o = (wp_q == rp_q);
    assign head_o  = mem_q[rp_q[AW-1:0]];
    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (clr_i) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (do_push) wp_d = wp_q + 1'b1;
            if (do_pop)  rp_d = rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/candy_ie.sv
// CANDY instruction encoder/loader: packs field bundles into 24-bit
// words, buffers them, and streams them into instruction memory.
module candy_ie
    import candy_ie_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [5:0]        in_op,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [3:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              op_err,
    output logic              ovf_err,
    output logic [ADDR_W:0]   word_count
);

    function automatic logic [INSTR_W-1:0] encode(fields_t f);
        logic [INSTR_W-1:0] w;
        w = '0;
        w[TYPE_LSB +: 2] = f.typ;
        case (f.typ)
            TYPE_R: begin
                w[R_OP_LSB +: 6]  = f.op;
                w[R_RS1_LSB +: 4] = f.rs1;
                w[R_RS2_LSB +: 4] = f.rs2;
                w[R_RD_LSB +: 4]  = f.rd;
            end
            TYPE_I, TYPE_S: begin
                w[IS_OP_LSB +: 4]  = f.op[3:0];
                w[IS_RS1_LSB +: 4] = f.rs1;
                w[IS_R2_LSB +: 4]  = (f.typ == TYPE_I) ? f.rd : f.rs2;
                w[9:0]             = f.imm[9:0];
            end
            default: begin
                w[U_OP_LSB +: 2] = f.op[1:0];
                w[U_RD_LSB +: 4] = f.rd;
                w[15:0]          = f.imm;
            end
        endcase
        return w;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                end_q, end_d;
    logic                op_err_q, op_err_d;
    logic                ovf_q, ovf_d;

    fields_t             fld;
    logic [INSTR_W-1:0]  head;
    logic                run, active, accept, bad_op;
    logic                push, pop, full, empty;
    logic                fifo_clr, wrap_hit;

    assign fld    = {in_type, in_op, in_rs1, in_rs2, in_rd, in_imm};
    assign run    = (state_q == ST_RUN);
    assign active = run || (state_q == ST_FLUSH);
    assign bad_op = op_overflow(fld);
    assign accept = in_valid && in_ready;
    assign push   = accept && !bad_op;
    assign pop    = mem_we && mem_ready;
    // end_q marks that the last address has been written; any word left
    // over after that point is an overflow.
    assign wrap_hit = active && end_q && !empty && !ovf_q;

    assign in_ready   = run && !full;
    assign mem_we     = !empty && active && !ovf_q && !end_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = head;
    assign busy       = active;
    assign done       = (state_q == ST_DONE);
    assign op_err     = op_err_q;
    assign ovf_err    = ovf_q;
    assign word_count = cnt_q;

    candy_ie_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (INSTR_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (fifo_clr),
        .push_i (push),
        .din_i  (encode(fld)),
        .pop_i  (pop),
        .full_o (full),
        .empty_o(empty),
        .head_o (head)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        end_d    = end_q;
        op_err_d = op_err_q;
        ovf_d    = ovf_q;
        fifo_clr = 1'b0;
        if (start) begin
            state_d  = ST_RUN;
            addr_d   = base_addr;
            cnt_d    = '0;
            end_d    = 1'b0;
            op_err_d = 1'b0;
            ovf_d    = 1'b0;
            fifo_clr = 1'b1;
        end else begin
            if (accept && bad_op) op_err_d = 1'b1;
            if (pop) begin
                cnt_d = cnt_q + 1'b1;
                if (addr_q == '1) end_d = 1'b1;
                else addr_d = addr_q + 1'b1;
            end
            if (wrap_hit) begin
                ovf_d    = 1'b1;
                fifo_clr = 1'b1;
                state_d  = ST_DONE;
            end else begin
                case (state_q)
                    ST_RUN:   if (finish) state_d = ST_FLUSH;
                    ST_FLUSH: if (empty) state_d = ST_DONE;
                    default:  state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            end_q    <= 1'b0;
            op_err_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            end_q    <= end_d;
            op_err_q <= op_err_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_candy_ie.sv
// Directed bench for candy_ie: vector table for encodings plus
// sequences for stall, overflow, flush and async reset.
module tb_candy_ie;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, finish;
    logic [9:0]  base_addr;
    logic        in_valid, in_ready;
    logic [1:0]  in_type;
    logic [5:0]  in_op;
    logic [3:0]  in_rs1, in_rs2, in_rd;
    logic [15:0] in_imm;
    logic        mem_we, mem_ready;
    logic [9:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        busy, done, op_err, ovf_err;
    logic [10:0] word_count;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [23:0] data;
    } wr_t;
    wr_t wr_q[$];

    typedef struct {
        logic [1:0]  typ;
        logic [5:0]  op;
        logic [3:0]  rs1, rs2, rd;
        logic [15:0] imm;
        logic        drop;
        logic [23:0] word;
    } vec_t;
    vec_t vt[9];

    logic [23:0] rw[5];

    candy_ie #(.FIFO_DEPTH(4), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_op(in_op), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done),
        .op_err(op_err), .ovf_err(ovf_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && mem_we && mem_ready)
            wr_q.push_back('{mem_addr, mem_wdata});

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tmo(string name);
        checks++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    task automatic do_start(logic [9:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(logic [1:0] t, logic [5:0] op, logic [3:0] r1,
                        logic [3:0] r2, logic [3:0] rd, logic [15:0] imm);
        int n = 0;
        in_type = t; in_op = op; in_rs1 = r1;
        in_rs2 = r2; in_rd = rd; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) tmo("send");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_r(int k);
        send(2'b00, 6'(k), 4'(k), 4'(k + 1), 4'(k + 2), 16'h0);
    endtask

    initial begin
        int exp_cnt;
        int n;
        logic [9:0] exp_addr;
        logic exp_oe;

        vt[0] = '{2'b00, 6'h05, 4'h3, 4'h4, 4'h7, 16'hFFFF, 1'b0, 24'h053470};
        vt[1] = '{2'b01, 6'h02, 4'h1, 4'hF, 4'h2, 16'h03FF, 1'b0, 24'h484BFF};
        vt[2] = '{2'b11, 6'h01, 4'h9, 4'h9, 4'h5, 16'hBEEF, 1'b0, 24'hD5BEEF};
        vt[3] = '{2'b10, 6'h0F, 4'hA, 4'h5, 4'h9, 16'hFD23, 1'b0, 24'hBE9523};
        vt[4] = '{2'b00, 6'h3F, 4'hF, 4'hF, 4'hF, 16'h0000, 1'b0, 24'h3FFFF0};
        vt[5] = '{2'b01, 6'h12, 4'h1, 4'h1, 4'h1, 16'h0001, 1'b1, 24'h000000};
        vt[6] = '{2'b11, 6'h04, 4'h0, 4'h0, 4'h1, 16'h1234, 1'b1, 24'h000000};
        vt[7] = '{2'b11, 6'h03, 4'hF, 4'hF, 4'h0, 16'h0000, 1'b0, 24'hF00000};
        vt[8] = '{2'b10, 6'h10, 4'h2, 4'h2, 4'h2, 16'h0002, 1'b1, 24'h000000};
        rw[0] = 24'h011230; rw[1] = 24'h022340; rw[2] = 24'h033450;
        rw[3] = 24'h044560; rw[4] = 24'h055670;

        rst = 1'b1; start = 1'b0; finish = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_type = '0; in_op = '0; in_rs1 = '0;
        in_rs2 = '0; in_rd = '0; in_imm = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {op_err, ovf_err}, 0);
        chk("rst_count", word_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        @(negedge clk);
        chk("idle_finish_busy", busy, 0);
        chk("idle_finish_done", done, 0);

        // encoding table, base 0x010, memory always ready
        @(posedge clk); #1;
        do_start(10'h010);
        exp_cnt = 0; exp_addr = 10'h010; exp_oe = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(vt[i].typ, vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].imm);
            @(negedge clk);
            exp_oe = exp_oe | vt[i].drop;
            chk($sformatf("v%0d_we", i), mem_we, !vt[i].drop);
            chk($sformatf("v%0d_op_err", i), op_err, exp_oe);
            chk($sformatf("v%0d_count", i), word_count, exp_cnt);
            if (!vt[i].drop) begin
                chk($sformatf("v%0d_addr", i), mem_addr, exp_addr);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].word);
                exp_cnt++;
                exp_addr++;
            end
            @(posedge clk); #1;
        end
        chk("tbl_final_count", word_count, exp_cnt);

        // back-pressure: fill FIFO while memory stalls
        do_start(10'h100);
        mem_ready = 1'b0;
        wr_q.delete();
        for (int k = 1; k <= 4; k++) send_r(k);
        in_type = 2'b00; in_op = 6'd5; in_rs1 = 4'd5;
        in_rs2 = 4'd6; in_rd = 4'd7; in_imm = '0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, 10'h100);
        chk("stall_wdata", mem_wdata, rw[0]);
        @(negedge clk);
        chk("stall_addr_hold", mem_addr, 10'h100);
        chk("stall_wdata_hold", mem_wdata, rw[0]);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) tmo("stall_5th");
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("stall_nwrites", wr_q.size(), 5);
        for (int i = 0; i < wr_q.size() && i < 5; i++) begin
            chk($sformatf("stall_w%0d_addr", i), wr_q[i].addr, 10'h100 + 10'(i));
            chk($sformatf("stall_w%0d_data", i), wr_q[i].data, rw[i]);
        end

        // last-address overflow
        do_start(10'h3FE);
        wr_q.delete();
        for (int k = 1; k <= 3; k++) send_r(k);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ovf_err", ovf_err, 1);
        chk("ovf_done", done, 1);
        chk("ovf_busy", busy, 0);
        chk("ovf_we", mem_we, 0);
        chk("ovf_count", word_count, 2);
        chk("ovf_nwrites", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("ovf_w0_addr", wr_q[0].addr, 10'h3FE);
            chk("ovf_w1_addr", wr_q[1].addr, 10'h3FF);
        end

        // finish drains the queue before DONE
        @(posedge clk); #1;
        do_start(10'h020);
        mem_ready = 1'b0;
        wr_q.delete();
        @(negedge clk);
        chk("restart_ovf_clear", ovf_err, 0);
        chk("restart_count", word_count, 0);
        @(posedge clk); #1;
        for (int k = 1; k <= 3; k++) send_r(k);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 1);
        chk("flush_done", done, 0);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_we", mem_we, 1);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) tmo("flush_done_wait");
        chk("flush_count", word_count, 3);
        chk("flush_nwrites", wr_q.size(), 3);
        if (wr_q.size() == 3) chk("flush_last", wr_q[2].data, rw[2]);

        // async reset while a write is stalled
        @(posedge clk); #1;
        do_start(10'h040);
        send_r(1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        send_r(2);
        @(negedge clk);
        chk("prerst_we", mem_we, 1);
        chk("prerst_addr", mem_addr, 10'h041);
        chk("prerst_count", word_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_count", word_count, 0);
        chk("arst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
